fetch_sequencer: RTL

Multi-cycle instruction sequencer that owns the program counter and fetches instructions over a req/ack memory handshake. It latches each instruction, classifies its format and drives seu_op to the sign-extension unit. It then holds the instruction for the execute datapath and computes the next PC from PC+4 or PC+extended offset. It sits between instruction memory and the datapath, replacing the free-running PC register of the single-cycle design.

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction sequencer.
// Owns the program counter, fetches one instruction at a time over a
// req/ack handshake, classifies its format for the sign-extension unit,
// presents it to the execute datapath, then advances the PC either by 4
// or by the SEU-extended branch offset.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_WORD = 32'hD4400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  seu_op,
    input  logic [63:0] ext_addr,
    input  logic        alu_zero,
    input  logic        exec_done,
    output logic [63:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // SEU format selects
    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_D  = 2'b01;
    localparam logic [1:0] SEU_B  = 2'b10;
    localparam logic [1:0] SEU_CB = 2'b11;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg;
    logic [31:0] instr_reg;
    logic        take_reg;

    logic        is_b;
    logic        is_cb;
    logic        is_dfmt;
    logic        take_next;
    logic [1:0]  seu_op_next;

    // Classify the latched instruction. Because instr_reg only changes on a
    // fetch ack, seu_op stays stable from DECODE until the next fetch lands.
    always_comb begin
        is_b        = (instr_reg[31:26] == 6'b000101);
        is_cb       = (instr_reg[31:25] == 7'b1011010);
        is_dfmt     = (instr_reg[31:21] == 11'b11111000010) ||
                      (instr_reg[31:21] == 11'b11111000000);
        seu_op_next = SEU_I;
        if (is_b) begin
            seu_op_next = SEU_B;
        end else if (is_cb) begin
            seu_op_next = SEU_CB;
        end else if (is_dfmt) begin
            seu_op_next = SEU_D;
        end
        // CBZ (bit 24 = 0) branches on zero, CBNZ (bit 24 = 1) on non-zero.
        take_next = is_b || (is_cb && (alu_zero ^ instr_reg[24]));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction latch, branch decision latch and PC update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
            take_reg  <= 1'b0;
        end else begin
            if (state_reg == S_FETCH && imem_ack) begin
                instr_reg <= imem_rdata;
            end
            if (state_reg == S_EXEC && exec_done) begin
                take_reg <= take_next;
            end
            if (state_reg == S_UPDATE) begin
                pc_reg <= take_reg ? (pc_reg + ext_addr) : (pc_reg + 64'd4);
            end
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (instr_reg == HALT_WORD) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign instr     = instr_reg;
    assign seu_op    = seu_op_next;

endmodule
